// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory-bus slave port between m0 (CPU) and m1 (DMA/debug).
// Grant FSM locks onto a master whose request stalls; an in-order ID FIFO routes read
// data valids back to the issuing master.
// Optional build macro: MEM_BUS_ARBITER_ROUND_ROBIN_EN (alternating priority in IDLE).
module mem_bus_arbiter #(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_write_data,
  input  logic [3:0]  m0_byte_enable,
  input  logic        m0_write_req,
  input  logic        m0_read_req,
  output logic [31:0] m0_read_data,
  output logic        m0_read_data_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_write_data,
  input  logic [3:0]  m1_byte_enable,
  input  logic        m1_write_req,
  input  logic        m1_read_req,
  output logic [31:0] m1_read_data,
  output logic        m1_read_data_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_write_data,
  output logic [3:0]  s_byte_enable,
  output logic        s_write_req,
  output logic        s_read_req,
  input  logic [31:0] s_read_data,
  input  logic        s_read_data_valid,
  output logic        err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t state, state_next;

  logic                  grant_valid;
  logic                  grant_id;
  logic                  g_read;
  logic                  g_write;
  logic                  rd_block;
  logic                  g_ready;
  logic                  accepted;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  fifo_id [DEPTH];
  logic                  req0;
  logic                  req1;

  assign req0 = m0_read_req | m0_write_req;
  assign req1 = m1_read_req | m1_write_req;

`ifdef MEM_BUS_ARBITER_ROUND_ROBIN_EN
  logic last_id;

  // Remember which master was accepted last so contention alternates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         last_id <= 1'b1;
    else if (accepted) last_id <= grant_id;
  end
`endif

  // Grant selection: locked master in LOCKm, priority pick in IDLE; nothing while in reset.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (!reset) begin
      case (state)
        LOCK0: begin grant_valid = 1'b1; grant_id = 1'b0; end
        LOCK1: begin grant_valid = 1'b1; grant_id = 1'b1; end
        default: begin
`ifdef MEM_BUS_ARBITER_ROUND_ROBIN_EN
          if (req0 && req1) begin grant_valid = 1'b1; grant_id = ~last_id; end
          else if (req0)    begin grant_valid = 1'b1; grant_id = 1'b0; end
          else if (req1)    begin grant_valid = 1'b1; grant_id = 1'b1; end
`else
          if (req0)      begin grant_valid = 1'b1; grant_id = 1'b0; end
          else if (req1) begin grant_valid = 1'b1; grant_id = 1'b1; end
`endif
        end
      endcase
    end
  end

  // Slave-side mux and ready gating; a read is held off only while the ID FIFO is full.
  always_comb begin
    g_read        = grant_id ? m1_read_req  : m0_read_req;
    g_write       = grant_id ? m1_write_req : m0_write_req;
    rd_block      = fifo_full & g_read;
    g_ready       = grant_valid & s_ready & ~rd_block;
    m0_ready      = g_ready & ~grant_id;
    m1_ready      = g_ready & grant_id;
    s_read_req    = grant_valid & g_read & ~fifo_full;
    s_write_req   = grant_valid & g_write & ~rd_block;
    s_addr        = '0;
    s_write_data  = '0;
    s_byte_enable = '0;
    if (grant_valid) begin
      s_addr        = grant_id ? m1_addr        : m0_addr;
      s_write_data  = grant_id ? m1_write_data  : m0_write_data;
      s_byte_enable = grant_id ? m1_byte_enable : m0_byte_enable;
    end
    accepted = s_ready & (s_read_req | s_write_req);
    push     = s_ready & s_read_req;
  end

  // Grant FSM next state: lock on a stalled grant, release on acceptance or dropped request.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid && !accepted) state_next = grant_id ? LOCK1 : LOCK0;
      LOCK0:   if (accepted || !req0)        state_next = IDLE;
      LOCK1:   if (accepted || !req1)        state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Read return routing: head of the ID FIFO picks the master receiving the valid.
  always_comb begin
    fifo_full          = (count == CNT_FULL);
    fifo_empty         = (count == '0);
    pop                = s_read_data_valid & ~fifo_empty;
    m0_read_data       = s_read_data;
    m1_read_data       = s_read_data;
    m0_read_data_valid = pop & ~fifo_id[rd_ptr];
    m1_read_data_valid = pop & fifo_id[rd_ptr];
  end

  // ID FIFO pointers, occupancy and storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) fifo_id[i] <= 1'b0;
    end else begin
      if (push) begin
        fifo_id[wr_ptr] <= grant_id;
        wr_ptr          <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky error: read data returned with no read outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               err <= 1'b0;
    else if (s_read_data_valid && fifo_empty) err <= 1'b1;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (DEPTH_LOG2 = 2).
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_addr, m1_addr, m0_write_data, m1_write_data;
  logic [3:0]  m0_byte_enable, m1_byte_enable;
  logic        m0_write_req, m0_read_req, m1_write_req, m1_read_req;
  logic [31:0] m0_read_data, m1_read_data;
  logic        m0_read_data_valid, m1_read_data_valid;
  logic        s_ready;
  logic [31:0] s_addr, s_write_data;
  logic [3:0]  s_byte_enable;
  logic        s_write_req, s_read_req;
  logic [31:0] s_read_data;
  logic        s_read_data_valid;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset),
    .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_write_data(m0_write_data),
    .m0_byte_enable(m0_byte_enable), .m0_write_req(m0_write_req), .m0_read_req(m0_read_req),
    .m0_read_data(m0_read_data), .m0_read_data_valid(m0_read_data_valid),
    .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_write_data(m1_write_data),
    .m1_byte_enable(m1_byte_enable), .m1_write_req(m1_write_req), .m1_read_req(m1_read_req),
    .m1_read_data(m1_read_data), .m1_read_data_valid(m1_read_data_valid),
    .s_ready(s_ready), .s_addr(s_addr), .s_write_data(s_write_data),
    .s_byte_enable(s_byte_enable), .s_write_req(s_write_req), .s_read_req(s_read_req),
    .s_read_data(s_read_data), .s_read_data_valid(s_read_data_valid), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sample settle point after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    m0_addr = '0; m1_addr = '0; m0_write_data = '0; m1_write_data = '0;
    m0_byte_enable = '0; m1_byte_enable = '0;
    m0_write_req = 0; m0_read_req = 0; m1_write_req = 0; m1_read_req = 0;
    s_ready = 0; s_read_data = '0; s_read_data_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    settle();
    check("rst_m0_ready", {31'b0, m0_ready}, 0);
    check("rst_m1_ready", {31'b0, m1_ready}, 0);
    check("rst_s_req", {30'b0, s_read_req, s_write_req}, 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_err", {31'b0, err}, 0);
    cyc();
    reset = 1'b0;

    // Contended writes straight after reset.
    m0_addr = 32'h0000_00A0; m0_write_data = 32'h1111_0000; m0_byte_enable = 4'hF;
    m1_addr = 32'h0000_00A1; m1_write_data = 32'h2222_0000; m1_byte_enable = 4'h3;
    m0_write_req = 1; m1_write_req = 1; s_ready = 1;
    settle();
    check("t2_c1_addr", s_addr, 32'hA0);
    check("t2_c1_wdata", s_write_data, 32'h1111_0000);
    check("t2_c1_be", {28'b0, s_byte_enable}, 32'hF);
    check("t2_c1_rdy", {30'b0, m1_ready, m0_ready}, 32'b01);
    cyc();
`ifdef MEM_BUS_ARBITER_ROUND_ROBIN_EN
    settle();
    check("t2_c2_addr", s_addr, 32'hA1);
    check("t2_c2_rdy", {30'b0, m1_ready, m0_ready}, 32'b10);
    check("t2_c2_be", {28'b0, s_byte_enable}, 32'h3);
    cyc();
    settle();
    check("t2_c3_addr", s_addr, 32'hA0);
    check("t2_c3_rdy", {30'b0, m1_ready, m0_ready}, 32'b01);
`else
    settle();
    check("t2_c2_addr", s_addr, 32'hA0);
    check("t2_c2_rdy", {30'b0, m1_ready, m0_ready}, 32'b01);
    check("t2_c2_be", {28'b0, s_byte_enable}, 32'hF);
    cyc();
    settle();
    check("t2_c3_addr", s_addr, 32'hA0);
    check("t2_c3_rdy", {30'b0, m1_ready, m0_ready}, 32'b01);
`endif
    cyc();
    m0_write_req = 0;
    settle();
    check("t2_c4_addr", s_addr, 32'hA1);
    check("t2_c4_wr", {31'b0, s_write_req}, 1);
    check("t2_c4_rdy", {30'b0, m1_ready, m0_ready}, 32'b10);
    cyc();
    m1_write_req = 0;

    // Single m0 read, valid returns two cycles after issue.
    m0_addr = 32'h1000_0000; m0_read_req = 1; s_ready = 1;
    settle();
    check("t1_s_addr", s_addr, 32'h1000_0000);
    check("t1_s_rd", {30'b0, s_write_req, s_read_req}, 32'b01);
    check("t1_rdy", {30'b0, m1_ready, m0_ready}, 32'b01);
    cyc();
    m0_read_req = 0;
    settle();
    check("t1_idle_rd", {31'b0, s_read_req}, 0);
    cyc();
    s_read_data = 32'hCAFE_F00D; s_read_data_valid = 1;
    settle();
    check("t1_rdv", {30'b0, m1_read_data_valid, m0_read_data_valid}, 32'b01);
    check("t1_rdata", m0_read_data, 32'hCAFE_F00D);
    cyc();
    s_read_data_valid = 0;

    // m1 granted while the slave stalls; m0 must wait behind the lock.
    m1_addr = 32'h0000_0B01; m1_write_req = 1; s_ready = 0;
    settle();
    check("t3_idle_addr", s_addr, 32'h0B01);
    cyc();
    m0_addr = 32'h0000_0B00; m0_write_req = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t3_lock_addr", s_addr, 32'h0B01);
      check("t3_lock_rdy", {30'b0, m1_ready, m0_ready}, 0);
      cyc();
    end
    s_ready = 1;
    settle();
    check("t3_m1_acc_addr", s_addr, 32'h0B01);
    check("t3_m1_acc_rdy", {30'b0, m1_ready, m0_ready}, 32'b10);
    cyc();
    m1_write_req = 0;
    settle();
    check("t3_m0_acc_addr", s_addr, 32'h0B00);
    check("t3_m0_acc_rdy", {30'b0, m1_ready, m0_ready}, 32'b01);
    cyc();
    m0_write_req = 0;

    // Fill the ID FIFO with four m0 reads.
    m0_addr = 32'h0000_0C00; m0_read_req = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t4_fill_rdy", {31'b0, m0_ready}, 1);
      check("t4_fill_rd", {31'b0, s_read_req}, 1);
      cyc();
    end
    settle();
    check("t4_full_rdy", {31'b0, m0_ready}, 0);
    check("t4_full_rd", {31'b0, s_read_req}, 0);
    cyc();
    m0_read_req = 0; m0_write_req = 1;
    settle();
    check("t4_full_wr", {31'b0, s_write_req}, 1);
    check("t4_full_wr_rdy", {31'b0, m0_ready}, 1);
    cyc();
    m0_write_req = 0; m0_read_req = 1;
    settle();
    check("t4_full2_rdy", {31'b0, m0_ready}, 0);
    cyc();
    s_read_data_valid = 1;
    settle();
    check("t4_pop_rdv", {30'b0, m1_read_data_valid, m0_read_data_valid}, 32'b01);
    check("t4_pop_rdy", {31'b0, m0_ready}, 0);
    cyc();
    s_read_data_valid = 0;
    settle();
    check("t4_5th_rdy", {31'b0, m0_ready}, 1);
    check("t4_5th_rd", {31'b0, s_read_req}, 1);
    cyc();
    m0_read_req = 0;
    s_read_data_valid = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t4_drain_rdv", {30'b0, m1_read_data_valid, m0_read_data_valid}, 32'b01);
      cyc();
    end
    s_read_data_valid = 0;

    // Interleaved reads m0, m1, m0 with a same-cycle push and pop.
    m0_read_req = 1;
    settle();
    check("t5_a_rdy", {30'b0, m1_ready, m0_ready}, 32'b01);
    cyc();
    m0_read_req = 0; m1_read_req = 1;
    settle();
    check("t5_b_rdy", {30'b0, m1_ready, m0_ready}, 32'b10);
    cyc();
    m1_read_req = 0; m0_read_req = 1; s_read_data_valid = 1;
    settle();
    check("t5_c_rdy", {30'b0, m1_ready, m0_ready}, 32'b01);
    check("t5_c_rdv", {30'b0, m1_read_data_valid, m0_read_data_valid}, 32'b01);
    cyc();
    m0_read_req = 0;
    settle();
    check("t5_d_rdv", {30'b0, m1_read_data_valid, m0_read_data_valid}, 32'b10);
    cyc();
    settle();
    check("t5_e_rdv", {30'b0, m1_read_data_valid, m0_read_data_valid}, 32'b01);
    check("t5_e_err", {31'b0, err}, 0);
    cyc();

    // Valid with the FIFO empty, then reset in the middle of traffic.
    settle();
    check("t6_empty_rdv", {30'b0, m1_read_data_valid, m0_read_data_valid}, 0);
    cyc();
    s_read_data_valid = 0;
    settle();
    check("t6_err_set", {31'b0, err}, 1);
    cyc();
    settle();
    check("t6_err_held", {31'b0, err}, 1);
    m0_read_req = 1;
    settle();
    check("t6_burst_rd", {31'b0, s_read_req}, 1);
    cyc();
    m0_read_req = 0; m1_addr = 32'h0000_0D01; m1_write_req = 1; reset = 1;
    settle();
    check("t6_rst_rdy", {30'b0, m1_ready, m0_ready}, 0);
    check("t6_rst_sreq", {30'b0, s_read_req, s_write_req}, 0);
    check("t6_rst_addr", s_addr, 0);
    check("t6_rst_err", {31'b0, err}, 0);
    cyc();
    reset = 0; m1_write_req = 0; s_read_data_valid = 1;
    settle();
    check("t6_post_rdv", {30'b0, m1_read_data_valid, m0_read_data_valid}, 0);
    cyc();
    s_read_data_valid = 0;
    settle();
    check("t6_post_err", {31'b0, err}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
